// File: rtl/psum_collector_pkg.sv
// Shared types and constants for the systolic-column partial-sum collector.
// Holds the default word width, FSM encoding and the signed-overflow helper.
package psum_collector_pkg;

    localparam int OFMAP_BITWIDTH_DEF = 32;
    localparam int TILE_CNT_W         = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Two's complement add overflows when both operands agree in sign and the result does not.
    function automatic logic signed_add_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb
    );
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/psum_collector_sync_fifo.sv
// Single-clock FIFO with registered storage, used to buffer finished ofmap words.
// Push when full and pop when empty are ignored; simultaneous push/pop keeps the count.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Pointer and occupancy update.
    always_comb begin
        do_push  = push && (count_q != CNT_W'(DEPTH));
        do_pop   = pop && (count_q != CNT_W'(0));
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Status flags and head-of-queue read.
    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        empty    = (count_q == CNT_W'(0));
        count    = count_q;
        pop_data = mem_q[rd_ptr_q];
    end

    // Pointer/count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/psum_collector.sv
// Sink at the bottom of a systolic MAC column: accumulates partial sums across K-tiles
// and streams finished ofmap words out through a valid/ready FIFO.
module psum_collector
    import psum_collector_pkg::*;
#(
    parameter int OFMAP_BITWIDTH = OFMAP_BITWIDTH_DEF,
    parameter int NUM_OUT        = 4,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [TILE_CNT_W-1:0]     cfg_num_tiles,
    input  logic [OFMAP_BITWIDTH-1:0] psum_in,
    input  logic                      psum_valid,
    output logic                      psum_ready,
    output logic [OFMAP_BITWIDTH-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      ovf,
    output logic                      done
);

    localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int MSB   = OFMAP_BITWIDTH - 1;
    localparam logic [IDX_W-1:0] LAST_OUT = IDX_W'(NUM_OUT - 1);

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          out_idx_q, out_idx_d;
    logic [TILE_CNT_W-1:0]     tile_idx_q, tile_idx_d;
    logic [TILE_CNT_W-1:0]     last_tile_q, last_tile_d;
    logic                      ovf_q, ovf_d;
    logic [OFMAP_BITWIDTH-1:0] acc_q [NUM_OUT];
    logic [OFMAP_BITWIDTH-1:0] acc_d [NUM_OUT];

    logic                      xfer;
    logic                      first_tile;
    logic                      last_tile_hit;
    logic [OFMAP_BITWIDTH-1:0] addend;
    logic [OFMAP_BITWIDTH-1:0] sum;
    logic                      sum_ovf;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [CNT_W-1:0]          fifo_count;
    logic [OFMAP_BITWIDTH-1:0] fifo_head;

    // Handshake and adder; the first tile seeds the sum instead of reading stale accumulator data.
    always_comb begin
        first_tile    = (tile_idx_q == TILE_CNT_W'(0));
        last_tile_hit = (tile_idx_q == last_tile_q);
        psum_ready    = (state_q == ST_ACCUM) && (!last_tile_hit || !fifo_full);
        xfer          = psum_valid && psum_ready;
        addend        = first_tile ? {OFMAP_BITWIDTH{1'b0}} : acc_q[out_idx_q];
        sum           = addend + psum_in;
        sum_ovf       = !first_tile && signed_add_ovf(addend[MSB], psum_in[MSB], sum[MSB]);
    end

    // Run sequencing, index counters, accumulator writes and FIFO push.
    always_comb begin
        state_d     = state_q;
        out_idx_d   = out_idx_q;
        tile_idx_d  = tile_idx_q;
        last_tile_d = last_tile_q;
        ovf_d       = ovf_q;
        acc_d       = acc_q;
        fifo_push   = 1'b0;
        done        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_ACCUM;
                    out_idx_d   = IDX_W'(0);
                    tile_idx_d  = TILE_CNT_W'(0);
                    ovf_d       = 1'b0;
                    last_tile_d = (cfg_num_tiles == TILE_CNT_W'(0)) ? TILE_CNT_W'(0)
                                                                    : cfg_num_tiles - TILE_CNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (xfer) begin
                    ovf_d = ovf_q | sum_ovf;
                    if (last_tile_hit) begin
                        fifo_push = 1'b1;
                    end else begin
                        acc_d[out_idx_q] = sum;
                    end
                    if (out_idx_q == LAST_OUT) begin
                        out_idx_d = IDX_W'(0);
                        if (last_tile_hit) begin
                            state_d = ST_DRAIN;
                        end else begin
                            tile_idx_d = tile_idx_q + TILE_CNT_W'(1);
                        end
                    end else begin
                        out_idx_d = out_idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_DRAIN: begin
                if (fifo_count == CNT_W'(0)) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output side: out_data is forced to zero while nothing is buffered.
    always_comb begin
        out_valid = !fifo_empty;
        out_data  = fifo_empty ? {OFMAP_BITWIDTH{1'b0}} : fifo_head;
        fifo_pop  = out_valid && out_ready;
        ovf       = ovf_q;
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_idx_q   <= IDX_W'(0);
            tile_idx_q  <= TILE_CNT_W'(0);
            last_tile_q <= TILE_CNT_W'(0);
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_idx_q   <= out_idx_d;
            tile_idx_q  <= tile_idx_d;
            last_tile_q <= last_tile_d;
            ovf_q       <= ovf_d;
        end
    end

    // Accumulation buffer; every run overwrites an entry on tile 0 before reading it.
    always_ff @(posedge clk) begin
        acc_q <= acc_d;
    end

    sync_fifo #(
        .WIDTH (OFMAP_BITWIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (sum),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: instance a uses FIFO_DEPTH=8, instance b FIFO_DEPTH=2.
module tb_psum_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_start, b_start;
    logic [7:0]  a_cfg, b_cfg;
    logic [31:0] a_psum_in, b_psum_in;
    logic        a_psum_valid, b_psum_valid;
    logic        a_psum_ready, b_psum_ready;
    logic [31:0] a_out_data, b_out_data;
    logic        a_out_valid, b_out_valid;
    logic        a_out_ready, b_out_ready;
    logic        a_ovf, b_ovf;
    logic        a_done, b_done;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] a_got[$];
    logic [31:0] b_got[$];
    int          a_done_cnt = 0;
    int          b_done_cnt = 0;

    always #5 clk = ~clk;

    psum_collector dut_a (
        .clk(clk), .rst(rst), .start(a_start), .cfg_num_tiles(a_cfg),
        .psum_in(a_psum_in), .psum_valid(a_psum_valid), .psum_ready(a_psum_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .ovf(a_ovf), .done(a_done)
    );

    psum_collector #(.FIFO_DEPTH(2)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .cfg_num_tiles(b_cfg),
        .psum_in(b_psum_in), .psum_valid(b_psum_valid), .psum_ready(b_psum_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .ovf(b_ovf), .done(b_done)
    );

    // Record every output transfer and done pulse as seen at the clock edge.
    always @(posedge clk) begin
        if (!rst) begin
            if (a_out_valid && a_out_ready) a_got.push_back(a_out_data);
            if (b_out_valid && b_out_ready) b_got.push_back(b_out_data);
            if (a_done) a_done_cnt <= a_done_cnt + 1;
            if (b_done) b_done_cnt <= b_done_cnt + 1;
        end
    end

    task automatic start_run(input bit which, input logic [7:0] cfg);
        @(negedge clk);
        if (which) begin b_cfg = cfg; b_start = 1'b1; end
        else       begin a_cfg = cfg; a_start = 1'b1; end
        @(posedge clk);
        #1;
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    task automatic send(input bit which, input logic [31:0] v);
        int n;
        n = 0;
        @(negedge clk);
        if (which) begin b_psum_in = v; b_psum_valid = 1'b1; end
        else       begin a_psum_in = v; a_psum_valid = 1'b1; end
        while (!(which ? b_psum_ready : a_psum_ready) && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL send_timeout dut=%0d value=%0h: psum_ready never rose", which, v);
        end
        @(posedge clk);
        #1;
        a_psum_valid = 1'b0;
        b_psum_valid = 1'b0;
    endtask

    task automatic wait_done(input bit which, input int base);
        int n;
        n = 0;
        while (((which ? b_done_cnt : a_done_cnt) == base) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL done_timeout dut=%0d: no done pulse within 100 cycles", which);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (a_psum_ready !== 1'b0) begin errors++; $display("FAIL reset_psum_ready got %b exp 0", a_psum_ready); end
        checks++; if (a_out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got %b exp 0", a_out_valid); end
        checks++; if (a_out_data !== 32'd0)  begin errors++; $display("FAIL reset_out_data got %0h exp 0", a_out_data); end
        checks++; if (a_ovf !== 1'b0)        begin errors++; $display("FAIL reset_ovf got %b exp 0", a_ovf); end
        checks++; if (a_done !== 1'b0)       begin errors++; $display("FAIL reset_done got %b exp 0", a_done); end
        checks++; if (b_out_valid !== 1'b0)  begin errors++; $display("FAIL reset_b_out_valid got %b exp 0", b_out_valid); end
    endtask

    task automatic test_passthrough();
        logic [31:0] exp_v [4];
        logic [31:0] got;
        int qb, db;
        exp_v = '{32'd10, -32'sd20, 32'd30, -32'sd40};
        qb = a_got.size();
        db = a_done_cnt;
        a_out_ready = 1'b1;
        start_run(1'b0, 8'd1);
        send(1'b0, exp_v[0]);
        checks++; if (a_out_valid !== 1'b1)   begin errors++; $display("FAIL pass_latency_valid got %b exp 1", a_out_valid); end
        checks++; if (a_out_data !== 32'd10) begin errors++; $display("FAIL pass_latency_data got %0h exp a", a_out_data); end
        for (int i = 1; i < 4; i++) send(1'b0, exp_v[i]);
        wait_done(1'b0, db);
        checks++;
        if (a_got.size() - qb != 4) begin errors++; $display("FAIL pass_count got %0d exp 4", a_got.size() - qb); end
        for (int i = 0; i < 4; i++) begin
            got = (qb + i < a_got.size()) ? a_got[qb + i] : 32'hxxxx_xxxx;
            checks++;
            if (got !== exp_v[i]) begin errors++; $display("FAIL pass_data[%0d] got %0h exp %0h", i, got, exp_v[i]); end
        end
        checks++;
        if (a_done_cnt - db != 1) begin errors++; $display("FAIL pass_done_pulses got %0d exp 1", a_done_cnt - db); end
    endtask

    task automatic test_two_tiles();
        logic [31:0] in_v [8];
        logic [31:0] exp_v [4];
        logic [31:0] got;
        int qb, db;
        in_v  = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd100, 32'd200, 32'd300, 32'd400};
        exp_v = '{32'd101, 32'd202, 32'd303, 32'd404};
        qb = a_got.size();
        db = a_done_cnt;
        a_out_ready = 1'b1;
        start_run(1'b0, 8'd2);
        for (int i = 0; i < 8; i++) send(1'b0, in_v[i]);
        wait_done(1'b0, db);
        checks++;
        if (a_got.size() - qb != 4) begin errors++; $display("FAIL tiles_count got %0d exp 4", a_got.size() - qb); end
        for (int i = 0; i < 4; i++) begin
            got = (qb + i < a_got.size()) ? a_got[qb + i] : 32'hxxxx_xxxx;
            checks++;
            if (got !== exp_v[i]) begin errors++; $display("FAIL tiles_data[%0d] got %0h exp %0h", i, got, exp_v[i]); end
        end
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL tiles_ovf got %b exp 0", a_ovf); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_v [4];
        logic [31:0] got;
        int qb, db;
        exp_v = '{32'd5, 32'd6, 32'd7, 32'd8};
        qb = b_got.size();
        db = b_done_cnt;
        b_out_ready = 1'b0;
        start_run(1'b1, 8'd1);
        send(1'b1, exp_v[0]);
        send(1'b1, exp_v[1]);
        @(negedge clk);
        b_psum_in = exp_v[2];
        b_psum_valid = 1'b1;
        checks++; if (b_psum_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %b exp 0", b_psum_ready); end
        repeat (3) @(negedge clk);
        checks++; if (b_psum_ready !== 1'b0)  begin errors++; $display("FAIL bp_ready_held got %b exp 0", b_psum_ready); end
        checks++; if (b_out_valid !== 1'b1)   begin errors++; $display("FAIL bp_out_valid got %b exp 1", b_out_valid); end
        checks++; if (b_out_data !== 32'd5)   begin errors++; $display("FAIL bp_head_stable got %0h exp 5", b_out_data); end
        checks++; if (b_done_cnt != db)       begin errors++; $display("FAIL bp_early_done got %0d exp 0", b_done_cnt - db); end
        b_out_ready = 1'b1;
        send(1'b1, exp_v[2]);
        send(1'b1, exp_v[3]);
        wait_done(1'b1, db);
        checks++;
        if (b_got.size() - qb != 4) begin errors++; $display("FAIL bp_count got %0d exp 4", b_got.size() - qb); end
        for (int i = 0; i < 4; i++) begin
            got = (qb + i < b_got.size()) ? b_got[qb + i] : 32'hxxxx_xxxx;
            checks++;
            if (got !== exp_v[i]) begin errors++; $display("FAIL bp_data[%0d] got %0h exp %0h", i, got, exp_v[i]); end
        end
        checks++;
        if (b_done_cnt - db != 1) begin errors++; $display("FAIL bp_done_pulses got %0d exp 1", b_done_cnt - db); end
    endtask

    task automatic test_overflow();
        logic [31:0] in_v [8];
        logic [31:0] exp_v [4];
        logic [31:0] got;
        int qb, db;
        in_v  = '{32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0};
        exp_v = '{32'h8000_0000, 32'd0, 32'd0, 32'd0};
        qb = a_got.size();
        db = a_done_cnt;
        a_out_ready = 1'b1;
        start_run(1'b0, 8'd2);
        for (int i = 0; i < 8; i++) send(1'b0, in_v[i]);
        wait_done(1'b0, db);
        for (int i = 0; i < 4; i++) begin
            got = (qb + i < a_got.size()) ? a_got[qb + i] : 32'hxxxx_xxxx;
            checks++;
            if (got !== exp_v[i]) begin errors++; $display("FAIL ovf_data[%0d] got %0h exp %0h", i, got, exp_v[i]); end
        end
        checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", a_ovf); end
        repeat (5) @(negedge clk);
        checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", a_ovf); end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] in_v [8];
        logic [31:0] exp_v [4];
        logic [31:0] got;
        int qb, db;
        a_out_ready = 1'b0;
        start_run(1'b0, 8'd1);
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL start_clears_ovf got %b exp 0", a_ovf); end
        send(1'b0, 32'd11);
        send(1'b0, 32'd22);
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL mid_buffered got %b exp 1", a_out_valid); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (a_out_valid !== 1'b0)  begin errors++; $display("FAIL mid_rst_out_valid got %b exp 0", a_out_valid); end
        checks++; if (a_psum_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b exp 0", a_psum_ready); end
        checks++; if (a_out_data !== 32'd0)  begin errors++; $display("FAIL mid_rst_out_data got %0h exp 0", a_out_data); end
        a_psum_in = 32'd999;
        a_psum_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (a_psum_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %b exp 0", a_psum_ready); end
        a_psum_valid = 1'b0;
        in_v  = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd100, 32'd200, 32'd300, 32'd400};
        exp_v = '{32'd101, 32'd202, 32'd303, 32'd404};
        a_out_ready = 1'b1;
        qb = a_got.size();
        db = a_done_cnt;
        start_run(1'b0, 8'd2);
        for (int i = 0; i < 8; i++) send(1'b0, in_v[i]);
        wait_done(1'b0, db);
        checks++;
        if (a_got.size() - qb != 4) begin errors++; $display("FAIL rerun_count got %0d exp 4", a_got.size() - qb); end
        for (int i = 0; i < 4; i++) begin
            got = (qb + i < a_got.size()) ? a_got[qb + i] : 32'hxxxx_xxxx;
            checks++;
            if (got !== exp_v[i]) begin errors++; $display("FAIL rerun_data[%0d] got %0h exp %0h", i, got, exp_v[i]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        a_start = 1'b0; b_start = 1'b0;
        a_cfg = 8'd0; b_cfg = 8'd0;
        a_psum_in = 32'd0; b_psum_in = 32'd0;
        a_psum_valid = 1'b0; b_psum_valid = 1'b0;
        a_out_ready = 1'b0; b_out_ready = 1'b0;
        test_reset();
        test_passthrough();
        test_two_tiles();
        test_backpressure();
        test_overflow();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
